// File: rtl/bsg_xor_fold_pkg.sv
// Shared types and helpers for the streaming XOR folder.
package bsg_xor_fold_pkg;

  // Control FSM: collecting a frame, or holding a folded result.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } fold_state_e;

  // Width of a counter that must represent 0..els inclusive.
  function automatic int count_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_xor_fold_ctrl.sv
// Frame control for bsg_xor_fold: FSM, word counter, handshake outputs
// and the accumulate/load enables for the datapath in the top level.
module bsg_xor_fold_ctrl
  import bsg_xor_fold_pkg::*;
#(
  parameter int els_p       = 4,
  parameter int cnt_width_p = count_width(els_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic                   last_i,
  input  logic                   yumi_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic                   first_o,
  output logic                   acc_en_o,
  output logic                   load_o,
  output logic [cnt_width_p-1:0] count_n_o
);

  localparam logic [cnt_width_p-1:0] els_lp = cnt_width_p'(els_p);

  fold_state_e            state_r;
  logic [cnt_width_p-1:0] cnt_r;
  logic                   v_r;
  logic                   accept;
  logic                   close;

  // No bypass: a held result blocks input even on the yumi cycle.
  assign ready_o   = ~v_r;
  assign v_o       = v_r;
  assign accept    = v_i & ready_o;
  assign count_n_o = cnt_r + cnt_width_p'(1);
  assign close     = accept & ((count_n_o == els_lp) | last_i);
  // The first word of a frame must not see the stale accumulator.
  assign first_o   = (cnt_r == '0);
  assign acc_en_o  = accept & ~close;
  assign load_o    = close;

  // Frame FSM with registered valid; counter clears whenever a frame closes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= EMPTY;
      cnt_r   <= '0;
      v_r     <= 1'b0;
    end else begin
      unique case (state_r)
        EMPTY, ACCUM: begin
          if (accept) begin
            if (close) begin
              state_r <= FULL;
              cnt_r   <= '0;
              v_r     <= 1'b1;
            end else begin
              state_r <= ACCUM;
              cnt_r   <= count_n_o;
            end
          end
        end
        FULL: begin
          if (yumi_i) begin
            state_r <= EMPTY;
            v_r     <= 1'b0;
          end
        end
        default: begin
          state_r <= EMPTY;
          cnt_r   <= '0;
          v_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bsg_xor_fold.sv
// Streaming XOR folder: XOR-reduces frames of up to els_p words into one
// word presented on a valid/yumi port. Optional registered parity output
// is enabled by defining BSG_XOR_FOLD_PARITY_EN.
module bsg_xor_fold
  import bsg_xor_fold_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            v_i,
  input  logic [width_p-1:0]              data_i,
  input  logic                            last_i,
  output logic                            ready_o,
  output logic                            v_o,
  output logic [width_p-1:0]              data_o,
  output logic [count_width(els_p)-1:0]   count_o,
  input  logic                            yumi_i
`ifdef BSG_XOR_FOLD_PARITY_EN
  ,
  output logic                            parity_o
`endif
);

  localparam int cnt_w_lp = count_width(els_p);

  logic                first;
  logic                acc_en;
  logic                load;
  logic [cnt_w_lp-1:0] count_n;
  logic [width_p-1:0]  acc_r;
  logic [width_p-1:0]  data_r;
  logic [cnt_w_lp-1:0] count_r;
  logic [width_p-1:0]  next_data;

  bsg_xor_fold_ctrl #(
    .els_p       (els_p),
    .cnt_width_p (cnt_w_lp)
  ) ctrl (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .last_i    (last_i),
    .yumi_i    (yumi_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .first_o   (first),
    .acc_en_o  (acc_en),
    .load_o    (load),
    .count_n_o (count_n)
  );

  assign next_data = (first ? '0 : acc_r) ^ data_i;

  // Running XOR of the words accepted so far in the open frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_r <= '0;
    end else if (acc_en) begin
      acc_r <= next_data;
    end
  end

  // Result registers, loaded on the frame-closing word and held until reloaded.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (load) begin
      data_r  <= next_data;
      count_r <= count_n;
    end
  end

  assign data_o  = data_r;
  assign count_o = count_r;

`ifdef BSG_XOR_FOLD_PARITY_EN
  logic parity_r;

  // Parity of the loaded result, registered alongside data_o.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      parity_r <= 1'b0;
    end else if (load) begin
      parity_r <= ^next_data;
    end
  end

  assign parity_o = parity_r;
`endif

`ifndef SYNTHESIS
  // Consumer may only take a result that is actually valid.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  // Upstream must hold a stalled word steady until it is accepted.
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   (v_i && !ready_o) |=> (v_i && $stable(data_i)));
`endif

endmodule

// File: tb/tb_bsg_xor_fold.sv
// Self-checking bench for bsg_xor_fold (width_p=32, els_p=4).
// Directed frames come from a vector table; a scoreboard queue receives
// expected results as closing words are driven and is drained by a monitor.
module tb_bsg_xor_fold;

  localparam int WIDTH = 32;
  localparam int ELS   = 4;
  localparam int CW    = $clog2(ELS + 1);

  logic             clk;
  logic             reset_n_i;
  logic             v_i;
  logic [WIDTH-1:0] data_i;
  logic             last_i;
  logic             ready_o;
  logic             v_o;
  logic [WIDTH-1:0] data_o;
  logic [CW-1:0]    count_o;
  logic             yumi_i;
`ifdef BSG_XOR_FOLD_PARITY_EN
  logic             parity_o;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    int          count;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        chk;
    logic [31:0] exp_data;
    int          exp_count;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[16];
  logic [31:0] m_acc;
  int          m_cnt;
  bit          consume_en;
  bit          prev_v;

  bsg_xor_fold #(
    .width_p (WIDTH),
    .els_p   (ELS)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .last_i    (last_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .count_o   (count_o),
    .yumi_i    (yumi_i)
`ifdef BSG_XOR_FOLD_PARITY_EN
    ,
    .parity_o  (parity_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each new result against the scoreboard, then drive yumi.
  always @(negedge clk) begin
    if (!reset_n_i) begin
      prev_v = 1'b0;
      yumi_i = 1'b0;
    end else begin
      if (v_o && !prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(v_o), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", data_o, e.data);
          chk("sb_count", 32'(count_o), 32'(e.count));
`ifdef BSG_XOR_FOLD_PARITY_EN
          chk("sb_parity", 32'(parity_o), 32'(^e.data));
`endif
          $display("result data=%h count=%0d", data_o, count_o);
        end
      end
      prev_v = v_o;
      yumi_i = v_o && consume_en;
    end
  end

  // Drive one word (called at a negedge), wait for acceptance, update model.
  task automatic send(input logic [31:0] d, input logic l, output bit closed);
    int          waits;
    int          n;
    logic [31:0] nxt;
    closed = 1'b0;
    v_i    = 1'b1;
    data_i = d;
    last_i = l;
    waits  = 0;
    while (!ready_o && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
      v_i = 1'b0;
      return;
    end
    n   = m_cnt + 1;
    nxt = ((m_cnt == 0) ? 32'd0 : m_acc) ^ d;
    if (n == ELS || l) begin
      exp_t e;
      e.data  = nxt;
      e.count = n;
      sb.push_back(e);
      m_cnt  = 0;
      closed = 1'b1;
    end else begin
      m_acc = nxt;
      m_cnt = n;
    end
    @(negedge clk);
    $display("accept data=%h last=%0b closes=%0b", d, l, closed);
    if (closed) begin
      chk("latency_v_o", 32'(v_o), 32'd1);
      chk("latency_ready_o", 32'(ready_o), 32'd0);
    end
  endtask

  task automatic idle();
    v_i    = 1'b0;
    last_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit closed;
    int waits;

    vecs[0]  = '{32'h0000_0001, 1'b0, 1'b0, 32'h0, 0};
    vecs[1]  = '{32'h0000_0002, 1'b0, 1'b0, 32'h0, 0};
    vecs[2]  = '{32'h0000_0004, 1'b0, 1'b0, 32'h0, 0};
    vecs[3]  = '{32'h0000_0008, 1'b0, 1'b1, 32'h0000_000F, 4};
    vecs[4]  = '{32'hFFFF_0000, 1'b0, 1'b0, 32'h0, 0};
    vecs[5]  = '{32'h0000_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 2};
    vecs[6]  = '{32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678, 1};
    vecs[7]  = '{32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0};
    vecs[8]  = '{32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0};
    vecs[9]  = '{32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0};
    vecs[10] = '{32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 4};
    vecs[11] = '{32'h0000_0007, 1'b1, 1'b1, 32'h0000_0007, 1};
    vecs[12] = '{32'h0000_0003, 1'b1, 1'b1, 32'h0000_0003, 1};
    vecs[13] = '{32'h0000_000A, 1'b0, 1'b0, 32'h0, 0};
    vecs[14] = '{32'h0000_000B, 1'b0, 1'b0, 32'h0, 0};
    vecs[15] = '{32'h0000_000C, 1'b1, 1'b1, 32'h0000_000D, 3};

    reset_n_i  = 1'b0;
    v_i        = 1'b0;
    data_i     = '0;
    last_i     = 1'b0;
    consume_en = 1'b1;
    m_acc      = '0;
    m_cnt      = 0;
    repeat (3) @(negedge clk);
    chk("reset_v_o", 32'(v_o), 32'd0);
    chk("reset_data_o", data_o, 32'd0);
    chk("reset_count_o", 32'(count_o), 32'd0);
    chk("reset_ready_o", 32'(ready_o), 32'd1);
`ifdef BSG_XOR_FOLD_PARITY_EN
    chk("reset_parity_o", 32'(parity_o), 32'd0);
`endif
    reset_n_i = 1'b1;
    @(negedge clk);

    // Table-driven directed frames, back-to-back with yumi following v_o.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].data, vecs[i].last, closed);
      chk("table_close", 32'(closed), 32'(vecs[i].chk));
      if (vecs[i].chk) begin
        chk("table_data", data_o, vecs[i].exp_data);
        chk("table_count", 32'(count_o), 32'(vecs[i].exp_count));
`ifdef BSG_XOR_FOLD_PARITY_EN
        chk("table_parity", 32'(parity_o), 32'(^vecs[i].exp_data));
`endif
      end
    end
    idle();

    // Backpressure: hold the result for 5 cycles with a word waiting.
    @(posedge clk);
    #1 consume_en = 1'b0;
    @(negedge clk);
    send(32'h0000_0010, 1'b0, closed);
    send(32'h0000_0020, 1'b0, closed);
    send(32'h0000_0040, 1'b0, closed);
    send(32'h0000_0080, 1'b0, closed);
    v_i    = 1'b1;
    data_i = 32'h0000_0055;
    last_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("hold cycle %0d v_o=%0b ready_o=%0b", k, v_o, ready_o);
      chk("bp_v_o", 32'(v_o), 32'd1);
      chk("bp_ready_o", 32'(ready_o), 32'd0);
      chk("bp_data_o", data_o, 32'h0000_00F0);
      chk("bp_count_o", 32'(count_o), 32'd4);
    end
    @(posedge clk);
    #1 consume_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_ready_o", 32'(ready_o), 32'd1);
    send(32'h0000_0055, 1'b1, closed);
    chk("bp_held_word_data", data_o, 32'h0000_0055);
    idle();
    idle();

    // Reset in the middle of a frame discards the partial accumulation.
    send(32'h0000_1111, 1'b0, closed);
    send(32'h0000_2222, 1'b0, closed);
    v_i       = 1'b0;
    last_i    = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("midrst_v_o", 32'(v_o), 32'd0);
    chk("midrst_data_o", data_o, 32'd0);
    chk("midrst_count_o", 32'(count_o), 32'd0);
    chk("midrst_ready_o", 32'(ready_o), 32'd1);
    m_acc = '0;
    m_cnt = 0;
    @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);
    send(32'h0000_00A5, 1'b1, closed);
    chk("postrst_data", data_o, 32'h0000_00A5);
    chk("postrst_count", 32'(count_o), 32'd1);
    idle();

    // Random frames scored against the reference model.
    for (int i = 0; i < 40; i++) begin
      send($urandom, ($urandom_range(0, 3) == 0), closed);
      if ($urandom_range(0, 3) == 0) idle();
    end
    send(32'h0BAD_F00D, 1'b1, closed);
    idle();

    waits = 0;
    while (sb.size() != 0 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_xor_fold.md
# bsg_xor_fold

Streaming XOR folder: accepts a stream of `width_p`-bit words over a valid/ready handshake and XOR-reduces each frame of up to `els_p` words into one word. A frame ends when its word count reaches `els_p` or when `last_i` is set. Each folded result is presented on a valid/yumi output port. It sits in datapath checksum and scrambler-check paths as the sequential, framed generalisation of the bitwise two-operand XOR.

## Interface
Parameters:
- `width_p`, 32, data word width; must be ≥1.
- `els_p`, 4, maximum words per frame; must be ≥1.

Ports:
- `clk_i`  in  1  sole clock; all flops are on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `v_i`  in  1  input word valid.
- `data_i`  in  `width_p`  input word.
- `last_i`  in  1  current input word closes the frame; only meaningful when `v_i` is high.
- `ready_o`  out  1  block can accept a word this cycle.
- `v_o`  out  1  folded result valid.
- `data_o`  out  `width_p`  folded result.
- `count_o`  out  `$clog2(els_p+1)`  number of words folded into `data_o`, range 1..`els_p`.
- `yumi_i`  in  1  consumer takes the result this cycle; legal only when `v_o` is high.
- `parity_o`  out  1  XOR of all bits of `data_o`. Present only with `BSG_XOR_FOLD_PARITY_EN`.

## Operation
- A word is accepted on any cycle where `v_i & ready_o`.
- `ready_o = ~v_o`, combinational. There is no bypass: the block accepts nothing while a result is held, even on the cycle `yumi_i` is high.
- Internal state: accumulator `acc_r`, frame counter `cnt_r`, and a 3-state FSM.
  - **EMPTY**: `cnt_r` = 0, `v_o` = 0.
  - **ACCUM**: 0 < `cnt_r` < `els_p`, `v_o` = 0.
  - **FULL**: `v_o` = 1.
- On an accepted word, `next = (cnt_r == 0 ? 0 : acc_r) ^ data_i` and `n = cnt_r + 1`.
  - If `n == els_p` or `last_i` is set: load `data_o` ← `next` and `count_o` ← `n`, clear `cnt_r`, go to FULL.
  - Otherwise: `acc_r` ← `next`, `cnt_r` ← `n`, go to (or stay in) ACCUM.
- In FULL, `data_o`, `count_o` and `v_o` are held stable until `yumi_i` is high. On `yumi_i`: clear `v_o` and go to EMPTY.
- `els_p` = 1: every word is its own frame, so `data_o` equals `data_i` one cycle after acceptance.
- Frames are not padded. A short frame (`last_i` early) folds only the words received.
- Reset mid-frame discards the partial accumulation and any held result.
- Illegal conditions, flagged by simulation-only assertions:
  - `yumi_i` high while `v_o` is low.
  - `v_i` dropping or `data_i` changing while `v_i & ~ready_o`. This is a protocol error on the upstream side.
- Outputs reset to: `v_o` = 0, `data_o` = 0, `count_o` = 0, `parity_o` = 0. `ready_o` = 1.

## Timing
- Latency: `v_o` rises in the cycle after the clock edge that accepted the frame-closing word.
- `data_o`, `count_o` and `parity_o` are all registered. `ready_o` is the only combinational output, and it depends only on state, not on any input.
- Peak throughput: one frame per `n + 1` cycles for an `n`-word frame with `yumi_i` tied high (n accepts, then one FULL cycle).
- Asynchronous reset assertion clears all state immediately. Release must be synchronised upstream; the block does not synchronise it internally.
- Counter wrap: `cnt_r` never exceeds `els_p - 1` because it is cleared on frame close.

## Configuration
- `BSG_XOR_FOLD_PARITY_EN` defined:
  - `parity_o` port exists.
  - It is registered in the same cycle as `data_o`, holds `^next` (the reduction XOR of the loaded result), and resets to 0.
- Not defined: the `parity_o` port and its flop are absent. All other behaviour is identical.

## Structure
- Package `bsg_xor_fold_pkg` holds:
  - the FSM state typedef (`EMPTY`, `ACCUM`, `FULL`);
  - a width helper for the `count_o` width, `$clog2(els_p+1)`.
- One sub-module, `bsg_xor_fold_ctrl`, contains the FSM, `cnt_r` and the `ready_o`/`v_o` generation, and drives the load/clear enables.
- The top level holds `acc_r` and the output data registers.

## Test plan
All scenarios use `width_p` = 32 and `els_p` = 4.

- **Full frame:** accept `0x1`, `0x2`, `0x4`, `0x8` back-to-back with `yumi_i` = 1 → `v_o` = 1 the cycle after the 4th accept, `data_o` = `0x0000000F`, `count_o` = 4, `ready_o` low that cycle.
- **Short frame:** accept `0xFFFF0000`, then `0x0000FFFF` with `last_i` = 1 → `data_o` = `0xFFFFFFFF`, `count_o` = 2. The next frame's first word is not XORed with old state.
- **Backpressure:** complete a frame, hold `yumi_i` = 0 for 5 cycles while `v_i` = 1 → `v_o`, `data_o` and `count_o` stay stable, `ready_o` = 0, no word accepted. Assert `yumi_i` → `ready_o` = 1 the next cycle.
- **Reset mid-frame:** accept 2 words, pull `reset_n_i` low for 1 cycle, release, then send `0xA5` with `last_i` → `data_o` = `0x000000A5`, `count_o` = 1. All outputs read 0 during reset.
- **Cancellation:** accept four words of `0xDEADBEEF` → `data_o` = 0, `count_o` = 4.
- **Parity (macro defined):** single word `0x7` with `last_i` → `parity_o` = 1. Word `0x3` → `parity_o` = 0.
